// File: rtl/usb_uart_in_arb_pkg.sv
// Shared types and defaults for the USB-UART IN arbiter.
// Used by usb_uart_in_arb and usb_rr_pick.
package usb_uart_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_BURST_DEF = 64;
  localparam int unsigned ARB_GAP_DEF       = 4;

  // Holder-index width; never narrower than one bit.
  function automatic int unsigned arb_idw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_uart_in_arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping at N-1 -> 0.
module usb_rr_pick
  import usb_uart_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = arb_idw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/usb_uart_in_arb.sv
// Round-robin, burst-holding arbiter sharing the USB-UART IN byte pipeline.
// Define USB_UART_ARB_DROP_EN to discard bytes while no host is present.
module usb_uart_in_arb
  import usb_uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 2,
  parameter  int unsigned MAX_BURST = ARB_MAX_BURST_DEF,
  parameter  int unsigned GAP       = ARB_GAP_DEF,
  localparam int unsigned IDW       = arb_idw(NUM_REQ)
) (
  input  logic                   clk_48mhz,
  input  logic                   reset_n,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_in_data,
  output logic                   uart_in_valid,
  input  logic                   uart_in_ready,
  input  logic                   host_present,
  output logic                   grant_active,
  output logic [IDW-1:0]         grant_id
`ifdef USB_UART_ARB_DROP_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;

  logic [7:0]     req_bytes [NUM_REQ];
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           hold_valid;
  logic           xfer;
  logic           drop;
  logic           consumed;
  logic           release_now;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  usb_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hold_valid = req_valid[grant_id_q];
  assign xfer       = uart_in_valid & uart_in_ready;
`ifdef USB_UART_ARB_DROP_EN
  assign drop       = (state_q == ARB_GRANT) & ~host_present & hold_valid;
`else
  assign drop       = 1'b0;
`endif
  assign consumed   = xfer | drop;
  // Gap expiry only advances while the host is present, matching the frozen gap counter.
  assign release_now = (state_q == ARB_GRANT) &
                       ((consumed & (burst_cnt_q == BW'(MAX_BURST - 1))) |
                        (host_present & ~hold_valid & (gap_cnt_q == GW'(GAP - 1))));

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    if (state_q == ARB_IDLE) begin
      if (pick_found) begin
        state_d    = ARB_GRANT;
        grant_id_d = pick_idx;
      end
    end else begin
      if (consumed) burst_cnt_d = burst_cnt_q + BW'(1);
      if (host_present) gap_cnt_d = hold_valid ? '0 : gap_cnt_q + GW'(1);
      if (release_now) begin
        state_d     = ARB_IDLE;
        rr_ptr_d    = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
        burst_cnt_d = '0;
        gap_cnt_d   = '0;
      end
    end
  end

  always_comb begin
    uart_in_data  = '0;
    uart_in_valid = 1'b0;
    req_ready     = '0;
    grant_active  = 1'b0;
    if (state_q == ARB_GRANT) begin
      grant_active  = 1'b1;
      uart_in_data  = req_bytes[grant_id_q];
      uart_in_valid = hold_valid & host_present;
`ifdef USB_UART_ARB_DROP_EN
      req_ready[grant_id_q] = host_present ? uart_in_ready : 1'b1;
`else
      req_ready[grant_id_q] = uart_in_ready & host_present;
`endif
    end
  end

  assign grant_id = grant_id_q;

`ifdef USB_UART_ARB_DROP_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_usb_uart_in_arb.sv
// Randomized self-checking bench for usb_uart_in_arb against a cycle-level
// reference model of the arbitration rules (grant, burst limit, idle gap, host gating).
module tb_usb_uart_in_arb;
  import usb_uart_arb_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned MAXB = 64;
  localparam int unsigned GAPC = 4;
  localparam int unsigned IDW  = arb_idw(NREQ);
  localparam int unsigned DW   = 8 * NREQ;
`ifdef USB_UART_ARB_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk_48mhz = 1'b0;
  logic             reset_n;
  logic [DW-1:0]    req_data;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [7:0]       uart_in_data;
  logic             uart_in_valid;
  logic             uart_in_ready;
  logic             host_present;
  logic             grant_active;
  logic [IDW-1:0]   grant_id;
`ifdef USB_UART_ARB_DROP_EN
  logic [15:0]      drop_count;
`endif

  usb_uart_in_arb #(.NUM_REQ(NREQ), .MAX_BURST(MAXB), .GAP(GAPC)) dut (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .uart_in_data  (uart_in_data),
    .uart_in_valid (uart_in_valid),
    .uart_in_ready (uart_in_ready),
    .host_present  (host_present),
    .grant_active  (grant_active),
    .grant_id      (grant_id)
`ifdef USB_UART_ARB_DROP_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus: per-producer valid probability (percent) and byte budget (-1 = endless).
  int          pv [NREQ];
  int          budget [NREQ];
  int unsigned seq [NREQ];
  int          pr = 100;
  int          ph = 100;
  int          adv = -1;

  // Reference model state.
  bit          m_hold;
  int unsigned m_id, m_ptr, m_bytes, m_streak, m_drop;

  int unsigned rx_total = 0;
  int          run_src = -1;
  int unsigned run_len = 0;
  int unsigned runs [$];

  function automatic logic [7:0] byte_of(input int unsigned i, input int unsigned s);
    return 8'((s * 7) + (i * 101) + 3);
  endfunction

  task automatic model_reset();
    m_hold = 1'b0; m_id = 0; m_ptr = 0; m_bytes = 0; m_streak = 0; m_drop = 0;
    adv = -1;
  endtask

  task automatic drive_inputs();
    logic [NREQ-1:0] v;
    logic [DW-1:0]   d;
    if (adv >= 0) begin
      seq[adv]++;
      if (budget[adv] > 0) budget[adv]--;
      adv = -1;
    end
    v = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (budget[i] != 0 && $urandom_range(99) < pv[i]) v = v | (NREQ'(1) << i);
      d = d | (DW'(byte_of(i, seq[i])) << (8 * i));
    end
    req_valid     = v;
    req_data      = d;
    uart_in_ready = ($urandom_range(99) < pr);
    host_present  = ($urandom_range(99) < ph);
  endtask

  task automatic model_step();
    logic [NREQ-1:0] er;
    logic [7:0]      ed;
    bit              ev, hv, tk;
    er = '0; ed = '0; ev = 1'b0; hv = 1'b0; tk = 1'b0;
    if (m_hold) begin
      hv = ((req_valid >> m_id) & NREQ'(1)) != '0;
      ev = hv && host_present;
      ed = byte_of(m_id, seq[m_id]);
      if (host_present ? uart_in_ready : DROP) er = NREQ'(1) << m_id;
    end
    check_eq("grant_active", grant_active, m_hold);
    check_eq("grant_id", grant_id, m_id);
    check_eq("uart_in_valid", uart_in_valid, ev);
    check_eq("uart_in_data", uart_in_data, ed);
    check_eq("req_ready", req_ready, er);
`ifdef USB_UART_ARB_DROP_EN
    check_eq("drop_count", drop_count, m_drop);
`endif
    if (uart_in_valid === 1'b1 && uart_in_ready === 1'b1) begin
      rx_total++;
      if (int'(grant_id) != run_src && run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      run_src = int'(grant_id);
      run_len++;
    end
    if (!m_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        int unsigned j = (m_ptr + k) % NREQ;
        if (!m_hold && (((req_valid >> j) & NREQ'(1)) != '0)) begin
          m_hold = 1'b1; m_id = j; m_bytes = 0; m_streak = 0;
        end
      end
    end else begin
      tk = host_present ? (hv && uart_in_ready) : (DROP && hv);
      if (tk) begin
        m_bytes++;
        adv = m_id;
        if (!host_present && m_drop < 65535) m_drop++;
      end
      if (host_present) m_streak = hv ? 0 : m_streak + 1;
      if ((tk && m_bytes == MAXB) || (host_present && m_streak == GAPC)) begin
        m_hold = 1'b0;
        m_ptr  = (m_id + 1) % NREQ;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_48mhz);
    model_step();
    @(posedge clk_48mhz);
    #1;
    drive_inputs();
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick();
  endtask

  int unsigned rx0;

  initial begin
    reset_n = 1'b0;
    req_valid = '0; req_data = '0; uart_in_ready = 1'b0; host_present = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pv[i] = 0; budget[i] = -1; seq[i] = 0; end
    model_reset();
    #1;
    check_eq("rst_grant_active", grant_active, 0);
    check_eq("rst_uart_in_valid", uart_in_valid, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_grant_id", grant_id, 0);
    repeat (2) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    @(posedge clk_48mhz);
    #1;
    drive_inputs();
    run(3);

    // Lone producer 0, ten bytes.
    budget[0] = 10; pv[0] = 100; pv[1] = 0;
    rx0 = rx_total;
    run(1);
    check_eq("arb_latency_idle", grant_active, 0);
    run(1);
    check_eq("arb_latency_grant", grant_active, 1);
    check_eq("arb_latency_id", grant_id, 0);
    run(18);
    check_eq("single_10_bytes", rx_total - rx0, 10);
    budget[0] = -1;

    // Both streaming: full 64-byte alternating runs.
    pv[0] = 100; pv[1] = 100;
    runs.delete(); run_src = -1; run_len = 0;
    run(300);
    check_eq("run_count", (runs.size() >= 4) ? 4 : runs.size(), 4);
    for (int k = 0; k < 4 && k < runs.size(); k++) check_eq("run_len", runs[k], MAXB);

    // Idle gap: 3 low cycles keep the grant, 4 release it.
    pv[0] = 0; pv[1] = 0;
    run(8);
    pv[0] = 100;
    run(3);
    pv[1] = 100;
    run(2);
    pv[0] = 0;
    run(3);
    pv[0] = 100;
    run(4);
    check_eq("gap3_active", grant_active, 1);
    check_eq("gap3_id", grant_id, 0);
    pv[0] = 0;
    run(4);
    pv[0] = 100;
    run(2);
    check_eq("gap4_active", grant_active, 1);
    check_eq("gap4_id", grant_id, 1);

    // Downstream backpressure for 20 cycles.
    pr = 0;
    run(1);
    rx0 = rx_total;
    run(19);
    check_eq("stall_no_xfer", rx_total - rx0, 0);
    pr = 100;
    run(5);

    // Host absent mid-burst.
    ph = 0;
    run(1);
    rx0 = rx_total;
    run(9);
    check_eq("nohost_no_xfer", rx_total - rx0, 0);
    ph = 100;
    run(100);

    // Asynchronous reset mid-burst.
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_grant_active", grant_active, 0);
    check_eq("midrst_uart_in_valid", uart_in_valid, 0);
    check_eq("midrst_req_ready", req_ready, 0);
    model_reset();
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    model_step();
    @(posedge clk_48mhz);
    #1;
    drive_inputs();
    check_eq("postrst_active", grant_active, 1);
    check_eq("postrst_id", grant_id, 0);
    run(20);

    // Randomized traffic.
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < NREQ; i++) pv[i] = int'($urandom_range(100, 20));
      pr = int'($urandom_range(100, 30));
      ph = int'($urandom_range(100, 60));
      run(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
